// File: rtl/punc_exec_pkg.sv
// Shared encodings for the PUnC execute engine: op codes, FSM states and
// the legality check that folds in the optional multiplier.
package punc_exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_PASS = 4'd3;
    localparam logic [3:0] OP_LEA  = 4'd4;
    localparam logic [3:0] OP_LD   = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_STI  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    // Everything up to SRA is always present; MUL only when the multiplier is built.
    localparam logic [3:0] OP_LAST_BASE = OP_SRA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MEM0 = 3'd2,
        ST_MEM1 = 3'd3,
        ST_ITER = 3'd4
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op, input bit mul_en);
        return (op <= OP_LAST_BASE) || ((op == OP_MUL) && mul_en);
    endfunction

endpackage

// File: rtl/punc_regfile_param.sv
// NREGS x DATA_W register file: one synchronous write port, three
// combinational read ports (two operands plus debug), async active-low clear.
module punc_regfile_param #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [RA_W-1:0]   ra0,
    input  logic [RA_W-1:0]   ra1,
    input  logic [RA_W-1:0]   rad,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rdd
);
    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[wa] <= wd;
        end
    end

    assign rd0 = regs_q[ra0];
    assign rd1 = regs_q[ra1];
    assign rdd = regs_q[rad];

endmodule

// File: rtl/punc_exec_unit.sv
// PUnC execute engine: accepts one decoded op, runs ALU / iterative shift-mul /
// req-ack memory work, writes back and updates N/Z/P.
//   state | meaning
//   IDLE  | op_ready high, waiting for op_valid
//   EXEC  | single-cycle ALU, EA compute, or launch of iterative work
//   MEM0  | first memory access (data for LD/ST, pointer for LDI/STI)
//   MEM1  | second access of LDI/STI at the fetched pointer
//   ITER  | one shift step or one shift-add multiply step per cycle
module punc_exec_unit
    import punc_exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter bit MUL_EN = 1'b1,
    parameter int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [RA_W-1:0]   op_dst,
    input  logic [RA_W-1:0]   op_src0,
    input  logic [RA_W-1:0]   op_src1,
    input  logic [DATA_W-1:0] op_imm,
    input  logic              op_use_imm,
    input  logic [DATA_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              err,
    output logic              n,
    output logic              z,
    output logic              p,
    input  logic [RA_W-1:0]   rf_debug_addr,
    output logic [DATA_W-1:0] rf_debug_data
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = SH_W + 1;

    state_e            state_q, state_d;
    logic [3:0]        opc_q, opc_d;
    logic [RA_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, pc_q, pc_d;
    logic [DATA_W-1:0] addr_q, addr_d, acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ui_q, ui_d, done_q, done_d, err_q, err_d;
    logic              n_q, n_d, z_q, z_d, p_q, p_d;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data, rd0, rd1, alu_res, sh_next, mul_next, ea;
    logic [SH_W-1:0]   shamt;

    punc_regfile_param #(.DATA_W(DATA_W), .NREGS(NREGS), .RA_W(RA_W)) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (wr_en),
        .wa  (dst_q),
        .wd  (wr_data),
        .ra0 (op_src0),
        .ra1 (op_src1),
        .rad (rf_debug_addr),
        .rd0 (rd0),
        .rd1 (rd1),
        .rdd (rf_debug_data)
    );

    assign ea       = a_q + imm_q;
    assign shamt    = imm_q[SH_W-1:0];
    assign mul_next = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        alu_res = a_q;
        sh_next = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
        case (opc_q)
            OP_ADD:  alu_res = a_q + (ui_q ? imm_q : b_q);
            OP_AND:  alu_res = a_q & (ui_q ? imm_q : b_q);
            OP_NOT:  alu_res = ~a_q;
            OP_LEA:  alu_res = pc_q + imm_q;
            default: alu_res = a_q;
        endcase
        case (opc_q)
            OP_SHL:  sh_next = acc_q << 1;
            OP_SHR:  sh_next = acc_q >> 1;
            default: sh_next = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        ui_d    = ui_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        n_d     = n_q;
        z_d     = z_q;
        p_d     = p_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    opc_d   = op_code;
                    dst_d   = op_dst;
                    a_d     = rd0;
                    b_d     = rd1;
                    imm_d   = op_imm;
                    ui_d    = op_use_imm;
                    pc_d    = pc;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!op_is_legal(opc_q, MUL_EN)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    case (opc_q)
                        OP_LD, OP_LDI, OP_ST, OP_STI: begin
                            addr_d  = ea;
                            state_d = ST_MEM0;
                        end
                        OP_SHL, OP_SHR, OP_SRA: begin
                            if (shamt == '0) begin
                                wr_en   = 1'b1;
                                wr_data = a_q;
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                acc_d   = a_q;
                                cnt_d   = {1'b0, shamt};
                                state_d = ST_ITER;
                            end
                        end
                        OP_MUL: begin
                            acc_d   = '0;
                            cnt_d   = CNT_W'(DATA_W);
                            state_d = ST_ITER;
                        end
                        default: begin
                            wr_en   = 1'b1;
                            wr_data = alu_res;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_MEM0: begin
                if (mem_ack) begin
                    case (opc_q)
                        OP_LD: begin
                            wr_en   = 1'b1;
                            wr_data = mem_rdata;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        OP_ST: begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            addr_d  = mem_rdata;
                            state_d = ST_MEM1;
                        end
                    endcase
                end
            end
            ST_MEM1: begin
                if (mem_ack) begin
                    wr_en   = (opc_q == OP_LDI);
                    wr_data = mem_rdata;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (opc_q == OP_MUL) begin
                    acc_d = mul_next;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = sh_next;
                end
                if (cnt_q == CNT_W'(1)) begin
                    wr_en   = 1'b1;
                    wr_data = (opc_q == OP_MUL) ? mul_next : sh_next;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            n_d = wr_data[DATA_W-1];
            z_d = (wr_data == '0);
            p_d = !wr_data[DATA_W-1] && (wr_data != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            ui_q    <= 1'b0;
            pc_q    <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            ui_q    <= ui_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            n_q     <= n_d;
            z_q     <= z_d;
            p_q     <= p_d;
        end
    end

    // Request is a pure decode of the state so reset drops it without a clock.
    assign op_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_MEM0) || (state_q == ST_MEM1);
    assign mem_we    = ((state_q == ST_MEM0) && (opc_q == OP_ST)) ||
                       ((state_q == ST_MEM1) && (opc_q == OP_STI));
    assign mem_addr  = addr_q;
    assign mem_wdata = b_q;
    assign done      = done_q;
    assign err       = err_q;
    assign n         = n_q;
    assign z         = z_q;
    assign p         = p_q;

endmodule

// File: tb/tb_punc_exec_unit.sv
// Directed bench for punc_exec_unit: ALU/shift/MUL vector table plus hand
// sequences for memory wait states, LDI/STI, illegal ops and mid-op reset.
module tb_punc_exec_unit;
    import punc_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0, op_valid0 = 1'b0;
    logic [3:0]  op_code = '0;
    logic [2:0]  op_dst = '0, op_src0 = '0, op_src1 = '0, rf_debug_addr = '0;
    logic [15:0] op_imm = '0, pc = '0;
    logic        op_use_imm = 1'b0;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic        op_ready, mem_req, mem_we, done, err, n, z, p;
    logic [15:0] mem_addr, mem_wdata, rf_debug_data;
    logic        op_ready0, mem_req0, mem_we0, done0, err0, n0, z0, p0;
    logic [15:0] mem_addr0, mem_wdata0, rf_debug_data0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wait_states = 0;
    int ack_cnt = 0, req_cyc = 0, unstable = 0;
    logic [15:0] mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    punc_exec_unit #(.DATA_W(16), .NREGS(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_dst(op_dst), .op_src0(op_src0), .op_src1(op_src1), .op_imm(op_imm),
        .op_use_imm(op_use_imm), .pc(pc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .err(err), .n(n), .z(z), .p(p),
        .rf_debug_addr(rf_debug_addr), .rf_debug_data(rf_debug_data)
    );

    punc_exec_unit #(.DATA_W(16), .NREGS(8), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid0), .op_ready(op_ready0), .op_code(op_code),
        .op_dst(op_dst), .op_src0(op_src0), .op_src1(op_src1), .op_imm(op_imm),
        .op_use_imm(op_use_imm), .pc(pc), .mem_req(mem_req0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done0), .err(err0), .n(n0), .z(z0), .p(p0),
        .rf_debug_addr(rf_debug_addr), .rf_debug_data(rf_debug_data0)
    );

    // Memory responder: acks after wait_states idle request cycles.
    initial begin
        int wcnt;
        logic prev_req, prev_we;
        logic [15:0] prev_addr, prev_wd;
        wcnt = 0; prev_req = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wd = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h30] = 16'h0040;
        mem[8'h40] = 16'hFFFF;
        forever begin
            @(negedge clk);
            if (mem_req && prev_req && !mem_ack &&
                (mem_addr != prev_addr || mem_we != prev_we || (mem_we && mem_wdata != prev_wd)))
                unstable++;
            prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wd = mem_wdata;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cyc++;
                if (wcnt >= wait_states) begin
                    mem_ack = 1'b1;
                    ack_cnt++;
                    wcnt = 0;
                    if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
                    else mem_rdata = mem[mem_addr[7:0]];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic rd(input bit sel, input logic [2:0] idx, output logic [15:0] v);
        rf_debug_addr = idx;
        #1;
        v = sel ? rf_debug_data0 : rf_debug_data;
    endtask

    // Issue one op to dut (sel=0) or dut0 (sel=1); lat = cycles from accept edge to done.
    task automatic issue(input bit sel, input logic [3:0] op, input logic [2:0] d, input logic [2:0] s0,
                         input logic [2:0] s1, input logic [15:0] imm, input logic ui,
                         input logic [15:0] pcv, output int lat, output logic errv);
        int a;
        int k;
        k = 0;
        @(negedge clk);
        while (!(sel ? op_ready0 : op_ready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_seen", sel ? op_ready0 : op_ready, 1);
        op_code = op; op_dst = d; op_src0 = s0; op_src1 = s1;
        op_imm = imm; op_use_imm = ui; pc = pcv;
        if (sel) op_valid0 = 1'b1; else op_valid = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        op_valid = 1'b0;
        op_valid0 = 1'b0;
        op_code = 4'hF; op_dst = '0; op_src0 = '0; op_src1 = '0; op_imm = 16'h5A5A; pc = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sel ? done0 : done) && k < 100);
        chk("done_seen", sel ? done0 : done, 1);
        lat = cyc - a;
        errv = sel ? err0 : err;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  dst;
        logic [2:0]  s0;
        logic [2:0]  s1;
        logic [15:0] imm;
        logic        ui;
        logic [15:0] pcv;
        logic [15:0] ev;
        logic [2:0]  nzp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int lat;
        logic e;
        logic [15:0] v;
        int a0, r0, u0;

        vecs[0]  = '{OP_ADD,  3'd1, 3'd0, 3'd0, 16'd5,    1'b1, 16'h0,   16'd5,    3'b001, 1};
        vecs[1]  = '{OP_ADD,  3'd2, 3'd1, 3'd1, 16'd0,    1'b0, 16'h0,   16'd10,   3'b001, 1};
        vecs[2]  = '{OP_AND,  3'd3, 3'd2, 3'd0, 16'd6,    1'b1, 16'h0,   16'd2,    3'b001, 1};
        vecs[3]  = '{OP_NOT,  3'd4, 3'd1, 3'd0, 16'd0,    1'b0, 16'h0,   16'hFFFA, 3'b100, 1};
        vecs[4]  = '{OP_PASS, 3'd5, 3'd0, 3'd0, 16'd0,    1'b0, 16'h0,   16'h0000, 3'b010, 1};
        vecs[5]  = '{OP_LEA,  3'd6, 3'd0, 3'd0, 16'hFFF0, 1'b1, 16'h100, 16'h00F0, 3'b001, 1};
        vecs[6]  = '{OP_ADD,  3'd7, 3'd4, 3'd0, 16'd6,    1'b1, 16'h0,   16'h0000, 3'b010, 1};
        vecs[7]  = '{OP_SHL,  3'd3, 3'd1, 3'd0, 16'd3,    1'b1, 16'h0,   16'h0028, 3'b001, 4};
        vecs[8]  = '{OP_SHR,  3'd4, 3'd4, 3'd0, 16'd2,    1'b1, 16'h0,   16'h3FFE, 3'b001, 3};
        vecs[9]  = '{OP_SHL,  3'd5, 3'd2, 3'd0, 16'd0,    1'b1, 16'h0,   16'h000A, 3'b001, 1};
        vecs[10] = '{OP_ADD,  3'd7, 3'd1, 3'd0, 16'h8000, 1'b1, 16'h0,   16'h8005, 3'b100, 1};
        vecs[11] = '{OP_MUL,  3'd6, 3'd1, 3'd2, 16'd0,    1'b0, 16'h0,   16'h0032, 3'b001, 17};
        vecs[12] = '{OP_ADD,  3'd1, 3'd0, 3'd0, 16'd3,    1'b1, 16'h0,   16'h0003, 3'b001, 1};
        vecs[13] = '{OP_ADD,  3'd2, 3'd0, 3'd0, 16'hFFFE, 1'b1, 16'h0,   16'hFFFE, 3'b100, 1};
        vecs[14] = '{OP_MUL,  3'd3, 3'd1, 3'd2, 16'd0,    1'b0, 16'h0,   16'hFFFA, 3'b100, 17};
        vecs[15] = '{OP_ADD,  3'd4, 3'd0, 3'd0, 16'h8000, 1'b1, 16'h0,   16'h8000, 3'b100, 1};
        vecs[16] = '{OP_SRA,  3'd5, 3'd4, 3'd0, 16'd4,    1'b1, 16'h0,   16'hF800, 3'b100, 5};
        vecs[17] = '{OP_SHR,  3'd6, 3'd4, 3'd0, 16'd15,   1'b1, 16'h0,   16'h0001, 3'b001, 16};
        vecs[18] = '{OP_ADD,  3'd1, 3'd0, 3'd0, 16'd5,    1'b1, 16'h0,   16'h0005, 3'b001, 1};
        vecs[19] = '{OP_SHL,  3'd7, 3'd1, 3'd0, 16'h0010, 1'b1, 16'h0,   16'h0005, 3'b001, 1};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_nzp", {n, z, p}, 3'b010);
        rd(1'b0, 3'd3, v);
        chk("rst_r3", v, 16'h0000);

        for (int i = 0; i < 20; i++) begin
            issue(1'b0, vecs[i].op, vecs[i].dst, vecs[i].s0, vecs[i].s1, vecs[i].imm,
                  vecs[i].ui, vecs[i].pcv, lat, e);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_err", i), e, 0);
            chk($sformatf("vec%0d_nzp", i), {n, z, p}, vecs[i].nzp);
            rd(1'b0, vecs[i].dst, v);
            chk($sformatf("vec%0d_val", i), v, vecs[i].ev);
        end

        // ST r1 (5) -> [0x20], zero wait states
        a0 = ack_cnt;
        issue(1'b0, OP_ST, 3'd0, 3'd0, 3'd1, 16'h0020, 1'b1, 16'h0, lat, e);
        chk("st_lat", lat, 2);
        chk("st_mem", mem[8'h20], 16'h0005);
        chk("st_nzp", {n, z, p}, 3'b001);
        chk("st_acks", ack_cnt - a0, 1);

        // LD r3 <- [0x20] with three wait states
        wait_states = 3;
        r0 = req_cyc; u0 = unstable;
        issue(1'b0, OP_LD, 3'd3, 3'd0, 3'd0, 16'h0020, 1'b1, 16'h0, lat, e);
        chk("ld_lat", lat, 5);
        chk("ld_req_cycles", req_cyc - r0, 4);
        chk("ld_addr_stable", unstable - u0, 0);
        chk("ld_nzp", {n, z, p}, 3'b001);
        rd(1'b0, 3'd3, v);
        chk("ld_val", v, 16'h0005);
        wait_states = 0;

        // LDI r2 <- [[0x30]] = [0x40] = 0xFFFF
        a0 = ack_cnt;
        issue(1'b0, OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0030, 1'b1, 16'h0, lat, e);
        chk("ldi_lat", lat, 3);
        chk("ldi_acks", ack_cnt - a0, 2);
        chk("ldi_nzp", {n, z, p}, 3'b100);
        rd(1'b0, 3'd2, v);
        chk("ldi_val", v, 16'hFFFF);

        // STI r1 (5) -> [[0x30]] = [0x40]
        a0 = ack_cnt;
        issue(1'b0, OP_STI, 3'd0, 3'd0, 3'd1, 16'h0030, 1'b1, 16'h0, lat, e);
        chk("sti_lat", lat, 3);
        chk("sti_acks", ack_cnt - a0, 2);
        chk("sti_mem", mem[8'h40], 16'h0005);
        chk("sti_nzp", {n, z, p}, 3'b100);

        // undefined op code
        issue(1'b0, 4'd14, 3'd2, 3'd1, 3'd1, 16'd1, 1'b1, 16'h0, lat, e);
        chk("ill_lat", lat, 1);
        chk("ill_err", e, 1);
        chk("ill_nzp", {n, z, p}, 3'b100);
        rd(1'b0, 3'd2, v);
        chk("ill_dst", v, 16'hFFFF);

        // MUL on the MUL_EN=0 build
        issue(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'd9, 1'b1, 16'h0, lat, e);
        chk("m0_add_err", e, 0);
        issue(1'b1, OP_MUL, 3'd1, 3'd1, 3'd1, 16'd0, 1'b0, 16'h0, lat, e);
        chk("m0_mul_err", e, 1);
        chk("m0_mul_lat", lat, 1);
        chk("m0_nzp", {n0, z0, p0}, 3'b001);
        rd(1'b1, 3'd1, v);
        chk("m0_dst", v, 16'h0009);

        // reset in the middle of an LDI with the request outstanding
        wait_states = 20;
        @(negedge clk);
        op_code = OP_LDI; op_dst = 3'd5; op_src0 = 3'd0; op_imm = 16'h0030; op_use_imm = 1'b1;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        @(negedge clk);
        chk("rstmid_req_seen", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_req_async", mem_req, 0);
        chk("rstmid_ready", op_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        wait_states = 0;
        @(negedge clk);
        chk("rstmid_done", done, 0);
        rd(1'b0, 3'd5, v);
        chk("rstmid_r5", v, 16'h0000);
        issue(1'b0, OP_ADD, 3'd1, 3'd0, 3'd0, 16'd7, 1'b1, 16'h0, lat, e);
        chk("post_lat", lat, 1);
        rd(1'b0, 3'd1, v);
        chk("post_val", v, 16'h0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
